rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32x32 register file. It shares the register file's single write port (WE3/A3/WD3) between two write-back requesters: the ALU pipe and the load/store unit (LSU). It tracks which destination registers have writes outstanding so the issue stage can detect RAW/WAW hazards. It sits between the execute/memory stages and the register file write port.

## Interface
- XLEN, 32, data width of write-back values and register file words
- AW, 5, register address width (2^AW registers; register 0 hard-wired zero)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU write-back request valid
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- lsu_valid  in  1  LSU write-back request valid
- lsu_rd  in  AW  LSU destination register
- lsu_data  in  XLEN  LSU load data
- lsu_ready  out  1  LSU request accepted this cycle
- rf_hold  in  1  block all grants while high
- alloc_en  in  1  issue stage allocates a pending write
- alloc_rd  in  AW  register being allocated
- chk_rs1, chk_rs2  in  AW each  source registers to hazard-check
- rs1_busy, rs2_busy  out  1 each  source has a write not yet visible in the register file
- rf_we  out  1  to register file WE3
- rf_waddr  out  AW  to register file A3
- rf_wdata  out  XLEN  to register file WD3
- busy_vec  out  2^AW  scoreboard, bit i = register i pending
- alloc_err  out  1  sticky: allocation to an already-busy register

## Operation
- Handshake: a request transfers when valid && ready. Ready may depend on valid; valid must not depend on ready. Once raised, valid and payload are held until ready.
- Arbitration: round-robin with 1-bit priority pointer `prio` (0 = ALU first, 1 = LSU first).
  - Both valid: grant the prioritized requester.
  - One valid: grant it.
  - After any grant, prio points to the non-granted unit. With no grant, prio is unchanged.
  - At most one grant per cycle.
- rf_hold=1: alu_ready=lsu_ready=0 and prio is frozen. The in-flight registered write still completes.
- Grant output: the registered write port loads from the winner: rf_we=1, rf_waddr=rd, rf_wdata=data.
  - Grant with rd=0: the request is consumed (ready=1) but rf_we=0 next cycle. No busy bit changes.
  - No grant: rf_we=0 next cycle. rf_waddr and rf_wdata hold their previous values.
- Scoreboard updates, evaluated at each edge:
  - alloc_en with alloc_rd!=0 and busy_vec[alloc_rd]=0: set the bit.
  - alloc_en with alloc_rd!=0 and busy_vec[alloc_rd]=1: no change; set alloc_err (sticky until reset).
  - alloc_rd=0: ignored.
  - A grant with rd!=0 clears busy_vec[rd].
  - Same register set by alloc and cleared by grant in one cycle: set wins, bit stays 1, no alloc_err.
- Hazard outputs (combinational): rsN_busy = (chk_rsN!=0) && (busy_vec[chk_rsN] || (rf_we && rf_waddr==chk_rsN)). This covers the cycle between busy-bit clear and the register file write landing.
- busy_vec[0] is always 0.

## Timing
- Reset (synchronous, dominates all other inputs): rf_we=0, rf_waddr=0, rf_wdata=0, busy_vec=0, alloc_err=0, prio=0.
  - During the reset cycle: alu_ready=lsu_ready=0.
- Latency: a grant in cycle N gives rf_we=1 in cycle N+1. The register file commits at the end of N+1. The busy bit reads 0 from cycle N+1.
- Throughput: one write per cycle sustained. With both requesters continuously valid, the grant pattern strictly alternates.
- Reset asserted mid-operation: any pending registered write is dropped (rf_we=0 next cycle) and every busy bit is lost. Upstream units are flushed by the same reset.

## Test plan
- Reset sequencing: both units valid, with reset held 2 cycles and then released. Required: no ready during reset, rf_we=0 during reset, first grant goes to the ALU (prio=0), then the LSU on the next cycle.
- Contention: both valid for 4 cycles (ALU rd=3, data 0xA; LSU rd=4, data 0xB). Required: grants ALU, LSU, ALU, LSU, with rf_waddr/rf_wdata following 3/0xA, 4/0xB, ... one cycle later.
- Scoreboard window: alloc rd=7, then ALU writes rd=7 (grant in cycle N). Required: busy_vec[7]=0 in N+1, and chk_rs1=7 gives rs1_busy=1 in N+1 (rf_we bypass) and 0 in N+2.
- x0 and errors: ALU write rd=0 gives ready=1 and rf_we=0. Alloc rd=0 leaves busy_vec unchanged. A second alloc to busy rd=5 sets alloc_err=1, which stays set until reset.
- Simultaneous set/clear: alloc rd=9 in the same cycle as an LSU grant to rd=9. Required: busy_vec[9]=1 afterwards, alloc_err=0.
- Hold: rf_hold=1 for 3 cycles with both units valid. Required: no ready and no rf_we after the in-flight write. On release, the grant goes to the unit prio pointed to before the hold.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the shared register-file write port, plus a pending-write
// scoreboard that the issue stage uses for RAW/WAW hazard detection.
module rf_wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [AW-1:0]     alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [AW-1:0]     lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              lsu_ready,
  input  logic              rf_hold,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_rd,
  input  logic [AW-1:0]     chk_rs1,
  input  logic [AW-1:0]     chk_rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic [2**AW-1:0]  busy_vec,
  output logic              alloc_err
);

  localparam int unsigned NREG = 2 ** AW;

  logic              prio_q, prio_d;
  logic              rf_we_q, rf_we_d;
  logic [AW-1:0]     rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic              alloc_err_q, alloc_err_d;

  logic              alu_gnt_c, lsu_gnt_c, gnt_any_c;
  logic [AW-1:0]     gnt_rd_c;
  logic [XLEN-1:0]   gnt_data_c;
  logic              alloc_hit_c;

  // Round-robin grant; reset and hold suppress every grant.
  always_comb begin
    alu_gnt_c = 1'b0;
    lsu_gnt_c = 1'b0;
    if (!reset && !rf_hold) begin
      if (alu_valid && lsu_valid) begin
        if (prio_q) lsu_gnt_c = 1'b1;
        else        alu_gnt_c = 1'b1;
      end else begin
        alu_gnt_c = alu_valid;
        lsu_gnt_c = lsu_valid;
      end
    end
    gnt_any_c  = alu_gnt_c | lsu_gnt_c;
    gnt_rd_c   = lsu_gnt_c ? lsu_rd   : alu_rd;
    gnt_data_c = lsu_gnt_c ? lsu_data : alu_data;
  end

  // Next-state for write port, priority pointer and scoreboard.
  always_comb begin
    prio_d      = prio_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    busy_d      = busy_q;
    alloc_hit_c = alloc_en && (alloc_rd != '0);

    if (alu_gnt_c)      prio_d = 1'b1;
    else if (lsu_gnt_c) prio_d = 1'b0;

    if (gnt_any_c && (gnt_rd_c != '0)) begin
      rf_we_d           = 1'b1;
      rf_waddr_d        = gnt_rd_c;
      rf_wdata_d        = gnt_data_c;
      busy_d[gnt_rd_c]  = 1'b0;
    end

    // Allocation is applied after the clear so a same-cycle set wins.
    if (alloc_hit_c && !busy_q[alloc_rd]) busy_d[alloc_rd] = 1'b1;
    busy_d[0] = 1'b0;

    alloc_err_d = alloc_err_q | (alloc_hit_c && busy_q[alloc_rd]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q      <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      busy_q      <= '0;
      alloc_err_q <= 1'b0;
    end else begin
      prio_q      <= prio_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      busy_q      <= busy_d;
      alloc_err_q <= alloc_err_d;
    end
  end

  // Hazard check also sees the write still in flight to the register file.
  assign rs1_busy = (chk_rs1 != '0) &&
                    (busy_q[chk_rs1] || (rf_we_q && (rf_waddr_q == chk_rs1)));
  assign rs2_busy = (chk_rs2 != '0) &&
                    (busy_q[chk_rs2] || (rf_we_q && (rf_waddr_q == chk_rs2)));

  assign alu_ready = alu_gnt_c;
  assign lsu_ready = lsu_gnt_c;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy_vec  = busy_q;
  assign alloc_err = alloc_err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: arbitration, write port timing, scoreboard, hold.
module tb_rf_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, lsu_valid, rf_hold, alloc_en;
  logic [AW-1:0]   alu_rd, lsu_rd, alloc_rd, chk_rs1, chk_rs2;
  logic [XLEN-1:0] alu_data, lsu_data;
  logic            alu_ready, lsu_ready, rs1_busy, rs2_busy, rf_we, alloc_err;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy_vec;

  int vecs = 0;
  int errs = 0;

  rf_wb_arbiter #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_hold(rf_hold), .alloc_en(alloc_en), .alloc_rd(alloc_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .busy_vec(busy_vec), .alloc_err(alloc_err)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge so registered outputs have settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; lsu_valid = 0; rf_hold = 0; alloc_en = 0;
    alu_rd = '0; lsu_rd = '0; alloc_rd = '0; chk_rs1 = '0; chk_rs2 = '0;
    alu_data = '0; lsu_data = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 5'd2; lsu_data = 32'h22;
    for (int c = 0; c < 2; c++) begin
      #1;
      vecs++; if (alu_ready !== 1'b0) begin errs++; $display("FAIL rst_alu_ready c%0d got %b exp 0", c, alu_ready); end
      vecs++; if (lsu_ready !== 1'b0) begin errs++; $display("FAIL rst_lsu_ready c%0d got %b exp 0", c, lsu_ready); end
      tick();
      vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL rst_rf_we c%0d got %b exp 0", c, rf_we); end
      vecs++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'h0) begin errs++; $display("FAIL rst_port c%0d got %0d/%h exp 0/0", c, rf_waddr, rf_wdata); end
      vecs++; if (busy_vec !== 32'h0 || alloc_err !== 1'b0) begin errs++; $display("FAIL rst_sb c%0d got %h/%b exp 0/0", c, busy_vec, alloc_err); end
    end
    reset = 0;
    #1;
    vecs++; if ({alu_ready, lsu_ready} !== 2'b10) begin errs++; $display("FAIL rel_first_grant got %b exp 10", {alu_ready, lsu_ready}); end
    tick();
    vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h11) begin errs++; $display("FAIL rel_first_write got %b/%0d/%h exp 1/1/11", rf_we, rf_waddr, rf_wdata); end
    #1;
    vecs++; if ({alu_ready, lsu_ready} !== 2'b01) begin errs++; $display("FAIL rel_second_grant got %b exp 01", {alu_ready, lsu_ready}); end
    tick();
    vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'h22) begin errs++; $display("FAIL rel_second_write got %b/%0d/%h exp 1/2/22", rf_we, rf_waddr, rf_wdata); end
    idle_inputs();
    tick();
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt;
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'hB;
    for (int c = 0; c < 4; c++) begin
      exp_gnt = (c % 2 == 0) ? 2'b10 : 2'b01;
      #1;
      vecs++; if ({alu_ready, lsu_ready} !== exp_gnt) begin errs++; $display("FAIL cont_grant c%0d got %b exp %b", c, {alu_ready, lsu_ready}, exp_gnt); end
      tick();
      if (c % 2 == 0) begin
        vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA) begin errs++; $display("FAIL cont_write c%0d got %b/%0d/%h exp 1/3/a", c, rf_we, rf_waddr, rf_wdata); end
      end else begin
        vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hB) begin errs++; $display("FAIL cont_write c%0d got %b/%0d/%h exp 1/4/b", c, rf_we, rf_waddr, rf_wdata); end
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard();
    alloc_en = 1; alloc_rd = 5'd7;
    tick();
    alloc_en = 0; chk_rs1 = 5'd7; chk_rs2 = 5'd0;
    #1;
    vecs++; if (busy_vec !== 32'h80 || rs1_busy !== 1'b1) begin errs++; $display("FAIL sb_alloc got %h/%b exp 80/1", busy_vec, rs1_busy); end
    vecs++; if (rs2_busy !== 1'b0) begin errs++; $display("FAIL sb_rs2_x0 got %b exp 0", rs2_busy); end
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h77;
    #1;
    vecs++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL sb_grant got %b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    #1;
    vecs++; if (busy_vec[7] !== 1'b0) begin errs++; $display("FAIL sb_clear_n1 got %b exp 0", busy_vec[7]); end
    vecs++; if (rf_we !== 1'b1 || rs1_busy !== 1'b1) begin errs++; $display("FAIL sb_bypass_n1 we %b rs1 %b exp 1/1", rf_we, rs1_busy); end
    tick();
    vecs++; if (rf_we !== 1'b0 || rs1_busy !== 1'b0) begin errs++; $display("FAIL sb_done_n2 we %b rs1 %b exp 0/0", rf_we, rs1_busy); end
    idle_inputs();
  endtask

  task automatic test_x0_err();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55;
    #1;
    vecs++; if (alu_ready !== 1'b1) begin errs++; $display("FAIL x0_ready got %b exp 1", alu_ready); end
    tick();
    alu_valid = 0;
    vecs++; if (rf_we !== 1'b0 || busy_vec !== 32'h0) begin errs++; $display("FAIL x0_write we %b busy %h exp 0/0", rf_we, busy_vec); end
    alloc_en = 1; alloc_rd = 5'd0;
    tick();
    vecs++; if (busy_vec !== 32'h0 || alloc_err !== 1'b0) begin errs++; $display("FAIL x0_alloc busy %h err %b exp 0/0", busy_vec, alloc_err); end
    alloc_rd = 5'd5;
    tick();
    vecs++; if (busy_vec !== 32'h20 || alloc_err !== 1'b0) begin errs++; $display("FAIL err_first busy %h err %b exp 20/0", busy_vec, alloc_err); end
    tick();
    vecs++; if (busy_vec !== 32'h20 || alloc_err !== 1'b1) begin errs++; $display("FAIL err_second busy %h err %b exp 20/1", busy_vec, alloc_err); end
    alloc_en = 0;
    alu_valid = 1; alu_rd = 5'd6; alu_data = 32'h66;
    tick();
    alu_valid = 0;
    vecs++; if (alloc_err !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd6) begin errs++; $display("FAIL err_sticky err %b we %b addr %0d exp 1/1/6", alloc_err, rf_we, rf_waddr); end
    // Mid-operation reset drops the in-flight write and the scoreboard.
    reset = 1; alu_valid = 1; alu_rd = 5'd8;
    #1;
    vecs++; if (alu_ready !== 1'b0) begin errs++; $display("FAIL midrst_ready got %b exp 0", alu_ready); end
    tick();
    reset = 0; alu_valid = 0;
    vecs++; if (rf_we !== 1'b0 || busy_vec !== 32'h0 || alloc_err !== 1'b0) begin errs++; $display("FAIL midrst_state we %b busy %h err %b exp 0/0/0", rf_we, busy_vec, alloc_err); end
    idle_inputs();
  endtask

  task automatic test_simul();
    alloc_en = 1; alloc_rd = 5'd9;
    lsu_valid = 1; lsu_rd = 5'd9; lsu_data = 32'h99;
    #1;
    vecs++; if ({alu_ready, lsu_ready} !== 2'b01) begin errs++; $display("FAIL simul_grant got %b exp 01", {alu_ready, lsu_ready}); end
    tick();
    idle_inputs();
    vecs++; if (busy_vec !== 32'h200 || alloc_err !== 1'b0) begin errs++; $display("FAIL simul_sb busy %h err %b exp 200/0", busy_vec, alloc_err); end
    vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h99) begin errs++; $display("FAIL simul_write got %b/%0d/%h exp 1/9/99", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_hold();
    // Grant the ALU so the pointer now favours the LSU.
    alu_valid = 1; alu_rd = 5'd10; alu_data = 32'hAA;
    tick();
    rf_hold = 1;
    alu_rd = 5'd11; alu_data = 32'hB1;
    lsu_valid = 1; lsu_rd = 5'd12; lsu_data = 32'hC1;
    #1;
    vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10) begin errs++; $display("FAIL hold_inflight we %b addr %0d exp 1/10", rf_we, rf_waddr); end
    for (int c = 0; c < 3; c++) begin
      #1;
      vecs++; if ({alu_ready, lsu_ready} !== 2'b00) begin errs++; $display("FAIL hold_ready c%0d got %b exp 00", c, {alu_ready, lsu_ready}); end
      tick();
      vecs++; if (rf_we !== 1'b0 || rf_waddr !== 5'd10 || rf_wdata !== 32'hAA) begin errs++; $display("FAIL hold_port c%0d got %b/%0d/%h exp 0/10/aa", c, rf_we, rf_waddr, rf_wdata); end
    end
    rf_hold = 0;
    #1;
    vecs++; if ({alu_ready, lsu_ready} !== 2'b01) begin errs++; $display("FAIL hold_release got %b exp 01", {alu_ready, lsu_ready}); end
    tick();
    vecs++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC1) begin errs++; $display("FAIL hold_write got %b/%0d/%h exp 1/12/c1", rf_we, rf_waddr, rf_wdata); end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clk);
    test_reset();
    test_contention();
    test_scoreboard();
    test_x0_err();
    test_simul();
    test_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
